// File: rtl/rr4_arbiter.sv
// Four-requester round-robin arbiter with break-before-make grant handover.
// Optional hold timeout is enabled by defining RR4_ARB_TIMEOUT_EN.
module rr4_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       rel,
    output logic [1:0] gnt_idx,
    output logic       gnt_en,
    output logic [7:0] busy_cnt
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

`ifdef RR4_ARB_TIMEOUT_EN
    localparam bit LP_TMO_EN = 1'b1;
`else
    localparam bit LP_TMO_EN = 1'b0;
`endif
    localparam logic [7:0] LP_LAST = 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [1:0] r_gnt_idx;
    logic       r_gnt_en;
    logic [7:0] r_busy;
    logic [1:0] r_last;

    state_t     w_nstate;
    logic [1:0] w_gnt_idx;
    logic       w_gnt_en;
    logic [7:0] w_busy;
    logic [1:0] w_last;
    logic [1:0] w_pick;
    logic [1:0] w_cand;
    logic       w_found;
    logic       w_hold;
    logic       w_tmo;

    // Scan from last+1 around to last; first requester found wins.
    always_comb begin
        w_pick  = r_last;
        w_found = 1'b0;
        w_cand  = r_last;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last + 2'(k);
            if (!w_found && req[w_cand]) begin
                w_pick  = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign w_hold = req[r_gnt_idx] && !rel;
    assign w_tmo  = LP_TMO_EN && (r_busy == LP_LAST);

    always_comb begin
        w_nstate  = r_state;
        w_gnt_idx = r_gnt_idx;
        w_gnt_en  = r_gnt_en;
        w_busy    = r_busy;
        w_last    = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_nstate  = S_GRANT;
                    w_gnt_idx = w_pick;
                    w_gnt_en  = 1'b1;
                    w_last    = w_pick;
                    w_busy    = 8'd0;
                end
            end
            S_GRANT: begin
                if (w_hold && !w_tmo) begin
                    if (r_busy != 8'hFF) begin
                        w_busy = r_busy + 8'd1;
                    end
                end else begin
                    w_nstate = S_IDLE;
                    w_gnt_en = 1'b0;
                    w_busy   = 8'd0;
                end
            end
            default: begin
                w_nstate = S_IDLE;
                w_gnt_en = 1'b0;
                w_busy   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_gnt_idx <= 2'b00;
            r_gnt_en  <= 1'b0;
            r_busy    <= 8'd0;
            r_last    <= 2'b11;
        end else begin
            r_state   <= w_nstate;
            r_gnt_idx <= w_gnt_idx;
            r_gnt_en  <= w_gnt_en;
            r_busy    <= w_busy;
            r_last    <= w_last;
        end
    end

    assign gnt_idx  = r_gnt_idx;
    assign gnt_en   = r_gnt_en;
    assign busy_cnt = r_busy;

endmodule
